// File: rtl/debounce_scan_pkg.sv
// debounce_scan_pkg: shared constants and width helpers for the scanned
// switch debouncer and its tick generator.
//   DEF_TICK_DIV : default clocks per scan tick (1 ms at 50 MHz)
//   DEF_CNT_MAX  : default consecutive disagreeing samples to accept a level
//   PRESS_CNT_W  : width of each per-channel press counter
//                  (present only with DEBOUNCE_SCAN_PRESS_COUNT_EN)
//   ch_w()       : index width for n items, never less than 1
//   cnt_w()      : integrator width able to hold 0..cmax
package debounce_scan_pkg;

  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_CNT_MAX  = 15;
  localparam int PRESS_CNT_W  = 8;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int cmax);
    return (cmax > 0) ? $clog2(cmax + 1) : 1;
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// debounce_tick_gen: free-running prescaler. It counts 0..TICK_DIV-1 and then
// wraps. tick is combinational and high for the single cycle in which the
// count sits at TICK_DIV-1. The sevseg digit scanner also uses this block.
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   tick  out one-cycle scan strobe
module debounce_tick_gen
  import debounce_scan_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int CW = ch_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: time-multiplexed debouncer for N_CH switches. One scan
// tick is shared round-robin, so each channel's integrator advances once
// every N_CH*TICK_DIV cycles. A channel accepts a new level after CNT_MAX
// consecutive disagreeing samples. Any agreeing sample clears its integrator.
//   CLK, RST_N in  clock and asynchronous active-low reset
//   switch_in  in  raw switch levels (asynchronous)
//   state      out debounced level per channel
//   trans_up   out one-cycle pulse on an accepted 0->1
//   trans_dn   out one-cycle pulse on an accepted 1->0
//   scan_ch    out channel serviced on the next tick (debug)
//   press_cnt  out 8-bit press counter per channel, bits [8i+7:8i]
//                  (only with DEBOUNCE_SCAN_PRESS_COUNT_EN defined)
module debounce_scan_ctrl
  import debounce_scan_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_MAX  = DEF_CNT_MAX
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_CH-1:0]           switch_in,
  output logic [N_CH-1:0]           state,
  output logic [N_CH-1:0]           trans_up,
  output logic [N_CH-1:0]           trans_dn,
  output logic [ch_w(N_CH)-1:0]     scan_ch
`ifdef DEBOUNCE_SCAN_PRESS_COUNT_EN
  ,
  output logic [N_CH*PRESS_CNT_W-1:0] press_cnt
`endif
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int CNT_W = cnt_w(CNT_MAX);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic            tick;
  logic [N_CH-1:0] sync1_q, sync_in;
  logic [CH_W-1:0] scan_q, scan_d;

  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .tick (tick)
  );

  // Two-flop synchronizer. sync_in lags switch_in by two cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync_in <= '0;
    end else begin
      sync1_q <= switch_in;
      sync_in <= sync1_q;
    end
  end

  always_comb begin
    scan_d = scan_q;
    if (tick) scan_d = (scan_q == CH_LAST) ? '0 : scan_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) scan_q <= '0;
    else        scan_q <= scan_d;
  end

  assign scan_ch = scan_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             st_q, st_d, up_q, up_d, dn_q, dn_d;
    logic             svc;

    // Only one channel matches scan_q, so at most one channel can pulse.
    assign svc = tick && (scan_q == CH_W'(i));

    always_comb begin
      cnt_d = cnt_q;
      st_d  = st_q;
      up_d  = 1'b0;
      dn_d  = 1'b0;
      if (svc) begin
        if (sync_in[i] == st_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          st_d  = sync_in[i];
          up_d  = sync_in[i];
          dn_d  = ~sync_in[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Pulses are registered together with the level, so each pulse
    // appears in the same cycle as the state change.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= '0;
        st_q  <= 1'b0;
        up_q  <= 1'b0;
        dn_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        st_q  <= st_d;
        up_q  <= up_d;
        dn_q  <= dn_d;
      end
    end

    assign state[i]    = st_q;
    assign trans_up[i] = up_q;
    assign trans_dn[i] = dn_q;

`ifdef DEBOUNCE_SCAN_PRESS_COUNT_EN
    logic [PRESS_CNT_W-1:0] pc_q;

    // Counts at the edge that ends the trans_up cycle and wraps naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)    pc_q <= '0;
      else if (up_q) pc_q <= pc_q + 1'b1;
    end

    assign press_cnt[i*PRESS_CNT_W +: PRESS_CNT_W] = pc_q;
`endif
  end

endmodule
